// File: rtl/rotate_arbiter.sv
// Round-robin arbiter feeding one shared two-stage rotate pipeline.
// S1 captures the winning request, S2 holds the rotated result.
module rotate_arbiter #(
    parameter int WIDTH      = 16,
    parameter int DIST_WIDTH = $clog2(WIDTH),
    parameter int NREQ       = 4,
    parameter int ID_WIDTH   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*WIDTH-1:0]      req_data,
    input  logic [NREQ*DIST_WIDTH-1:0] req_dist,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [ID_WIDTH-1:0]        out_id,
    output logic                       busy
);

    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("rotate_arbiter: WIDTH must be a power of two >= 2");
    end
    if ((2 ** DIST_WIDTH) > WIDTH) begin : g_bad_dist
        $error("rotate_arbiter: 2**DIST_WIDTH exceeds WIDTH");
    end
    if (NREQ < 1) begin : g_bad_nreq
        $error("rotate_arbiter: NREQ must be at least 1");
    end

    logic [ID_WIDTH-1:0]   ptr;
    logic                  s1_valid;
    logic [WIDTH-1:0]      s1_data;
    logic [DIST_WIDTH-1:0] s1_dist;
    logic [ID_WIDTH-1:0]   s1_id;
    logic                  s2_valid;
    logic [WIDTH-1:0]      s2_data;
    logic [ID_WIDTH-1:0]   s2_id;

    logic                  s2_load;
    logic                  s1_load;
    logic                  found;
    logic [ID_WIDTH-1:0]   winner;
    logic [ID_WIDTH-1:0]   ptr_next;
    logic                  accept;
    logic [2*NREQ-1:0]     rot_valid;
    logic [WIDTH-1:0]      sel_data;
    logic [DIST_WIDTH-1:0] sel_dist;
    logic [2*WIDTH-1:0]    dbl;
    logic [WIDTH-1:0]      rot_data;
    int                    cand;

    assign s2_load = !s2_valid || out_ready;
    assign s1_load = !s1_valid || s2_load;

    // Find the first valid requester at or after ptr, wrapping.
    always_comb begin
        found     = 1'b0;
        winner    = '0;
        cand      = 0;
        rot_valid = {req_valid, req_valid} >> ptr;
        for (int j = 0; j < NREQ; j++) begin
            if (!found && rot_valid[j]) begin
                found = 1'b1;
                cand  = int'(ptr) + j;
                if (cand >= NREQ) cand = cand - NREQ;
                winner = ID_WIDTH'(cand);
            end
        end
    end

    // Grant only when S1 can take the entry; reset masks every grant.
    always_comb begin
        accept    = found && s1_load && !rst;
        req_ready = '0;
        if (accept) req_ready = NREQ'(1) << winner;
        if (winner == ID_WIDTH'(NREQ - 1)) ptr_next = '0;
        else ptr_next = winner + 1'b1;
    end

    // Select the winning requester's word and distance.
    always_comb begin
        sel_data = '0;
        sel_dist = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == ID_WIDTH'(i)) begin
                sel_data = req_data[i*WIDTH +: WIDTH];
                sel_dist = req_dist[i*DIST_WIDTH +: DIST_WIDTH];
            end
        end
    end

    // Right rotate: shifting a doubled word brings the low bits around.
    always_comb begin
        dbl      = {s1_data, s1_data} >> s1_dist;
        rot_data = dbl[WIDTH-1:0];
    end

    // Pointer and capture stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_dist  <= '0;
            s1_id    <= '0;
        end else begin
            if (accept) ptr <= ptr_next;
            if (s1_load) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_data <= sel_data;
                    s1_dist <= sel_dist;
                    s1_id   <= winner;
                end
            end
        end
    end

    // Output stage holds its result until downstream takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_id    <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= rot_data;
                s2_id   <= s1_id;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_id    = s2_id;
    assign busy      = s1_valid | s2_valid;

endmodule

// File: tb/tb_rotate_arbiter.sv
// Testbench for rotate_arbiter: directed scenarios then random traffic,
// checked against a queue-based in-flight model.
module tb_rotate_arbiter;

    localparam int W  = 16;
    localparam int DW = 4;
    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_data;
    logic [N*DW-1:0] req_dist;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_data;
    logic [IW-1:0]   out_id;
    logic            busy;

    rotate_arbiter #(.WIDTH(W), .DIST_WIDTH(DW), .NREQ(N), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_dist(req_dist),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        int           id;
        int           age;
    } ent_t;

    int   checks   = 0;
    int   failures = 0;
    ent_t q[$];
    int   ptr = 0;
    int   got_ids[$];
    logic [W-1:0] got_data[$];
    int   grants[$];

    function automatic logic [W-1:0] rot(logic [W-1:0] d, int s);
        logic [W-1:0] r;
        for (int k = 0; k < W; k++) r[k] = d[(k + s) % W];
        return r;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(int i, logic [W-1:0] d, int s);
        req_data[i*W +: W]  = d;
        req_dist[i*DW +: DW] = s[DW-1:0];
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle();
        int         win;
        bit         ov;
        bit         pop;
        bit         acc;
        logic [N-1:0] exp_rdy;
        #1;
        win = -1;
        for (int off = 0; off < N; off++) begin
            int idx;
            idx = (ptr + off) % N;
            if (win < 0 && req_valid[idx]) win = idx;
        end
        ov  = (q.size() > 0) && (q[0].age >= 1);
        pop = ov && out_ready;
        acc = (win >= 0) && ((q.size() < 2) || pop);
        exp_rdy = '0;
        if (acc) exp_rdy[win] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(ov));
        chk("busy", 64'(busy), 64'(q.size() > 0));
        if (ov) begin
            chk("out_data", 64'(out_data), 64'(q[0].d));
            chk("out_id", 64'(out_id), 64'(q[0].id));
        end
        if (out_valid && out_ready) begin
            got_ids.push_back(int'(out_id));
            got_data.push_back(out_data);
        end
        for (int i = 0; i < N; i++)
            if (req_ready[i]) grants.push_back(i);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (acc) begin
            ent_t e;
            e.d   = rot(req_data[win*W +: W], int'(req_dist[win*DW +: DW]));
            e.id  = win;
            e.age = 0;
            q.push_back(e);
            ptr = (win + 1) % N;
        end
        @(negedge clk);
    endtask

    task automatic reset_plain();
        rst = 1'b1;
        q.delete();
        ptr = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_logs();
        got_ids.delete();
        got_data.delete();
        grants.delete();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_dist  = '0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_id", 64'(out_id), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        rst = 1'b0;

        // 1: requester 2 alone, rotate 0x0001 by 1
        clear_logs();
        set_req(2, 16'h0001, 1);
        req_valid = 4'b0100;
        cycle();
        req_valid = '0;
        cycle();
        cycle();
        chk("t1_grant", 64'(grants.size() > 0 ? grants[0] : -1), 64'(2));
        chk("t1_n", 64'(got_data.size()), 64'(1));
        chk("t1_data", 64'(got_data.size() > 0 ? got_data[0] : 16'hxxxx), 64'(16'h8000));
        chk("t1_id", 64'(got_ids.size() > 0 ? got_ids[0] : -1), 64'(2));

        // 2: requester 0 with several distances
        clear_logs();
        req_valid = 4'b0001;
        set_req(0, 16'h1234, 4);
        cycle();
        set_req(0, 16'h1234, 0);
        cycle();
        set_req(0, 16'h8000, 15);
        cycle();
        req_valid = '0;
        cycle();
        cycle();
        chk("t2_n", 64'(got_data.size()), 64'(3));
        if (got_data.size() == 3) begin
            chk("t2_d4", 64'(got_data[0]), 64'(16'h4123));
            chk("t2_d0", 64'(got_data[1]), 64'(16'h1234));
            chk("t2_d15", 64'(got_data[2]), 64'(16'h0001));
        end

        // 3: all requesters valid, round-robin with no bubbles
        reset_plain();
        clear_logs();
        for (int i = 0; i < N; i++) set_req(i, W'($urandom), int'($urandom_range(0, 15)));
        req_valid = 4'b1111;
        for (int c = 0; c < 6; c++) cycle();
        req_valid = '0;
        for (int c = 0; c < 3; c++) cycle();
        chk("t3_n", 64'(got_ids.size()), 64'(6));
        for (int k = 0; k < 6; k++)
            if (k < got_ids.size()) chk("t3_id", 64'(got_ids[k]), 64'(k % N));

        // 4: output stall, exactly two in flight, then drain in order
        clear_logs();
        out_ready = 1'b0;
        req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) cycle();
        chk("t4_acc", 64'(grants.size()), 64'(2));
        chk("t4_busy", 64'(busy), 64'(1));
        req_valid = '0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) cycle();
        chk("t4_n", 64'(got_ids.size()), 64'(2));
        if (got_ids.size() == 2) begin
            chk("t4_id0", 64'(got_ids[0]), 64'(2));
            chk("t4_id1", 64'(got_ids[1]), 64'(3));
        end

        // 5: ptr at 3 with requesters 1 and 3, then 3 withdraws
        reset_plain();
        clear_logs();
        req_valid = 4'b0100;
        cycle();
        req_valid = 4'b1010;
        for (int c = 0; c < 3; c++) cycle();
        req_valid = '0;
        cycle();
        cycle();
        chk("t5_n", 64'(grants.size()), 64'(4));
        if (grants.size() == 4) begin
            chk("t5_g1", 64'(grants[1]), 64'(3));
            chk("t5_g2", 64'(grants[2]), 64'(1));
            chk("t5_g3", 64'(grants[3]), 64'(3));
        end
        clear_logs();
        out_ready = 1'b0;
        req_valid = 4'b0100;
        cycle();
        cycle();
        req_valid = 4'b1010;
        cycle();
        cycle();
        req_valid = 4'b0010;
        out_ready = 1'b1;
        cycle();
        req_valid = '0;
        for (int c = 0; c < 3; c++) cycle();
        chk("t5_drop_n", 64'(grants.size()), 64'(3));
        if (grants.size() == 3) chk("t5_drop_g", 64'(grants[2]), 64'(1));

        // 6: asynchronous reset with two entries in flight
        clear_logs();
        out_ready = 1'b0;
        req_valid = 4'b1111;
        cycle();
        cycle();
        chk("t6_busy_pre", 64'(busy), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("t6_out_valid", 64'(out_valid), 64'(0));
        chk("t6_busy", 64'(busy), 64'(0));
        chk("t6_req_ready", 64'(req_ready), 64'(0));
        chk("t6_out_data", 64'(out_data), 64'(0));
        q.delete();
        ptr = 0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        clear_logs();
        cycle();
        chk("t6_first", 64'(grants.size() > 0 ? grants[0] : -1), 64'(0));

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            req_valid = N'($urandom);
            req_data  = {$urandom, $urandom};
            req_dist  = (N*DW)'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
